// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-player score keeper with faceoff hold and win detection
//
// Purpose: credits goals from goal-detect levels (rising edges only), keeps the
// two player scores, holds the faceoff for HOLD_CYCLES after a non-winning goal,
// and freezes the game once a player reaches WIN_SCORE until new_game or rst.
//
// Ports:
//   clock        in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   goal1_in     in   puck in player 1's scoring goal (level)
//   goal2_in     in   puck in player 2's scoring goal (level)
//   new_game     in   synchronous restart request
//   score1       out  player 1 score, 0..WIN_SCORE
//   score2       out  player 2 score, 0..WIN_SCORE
//   goal_pulse   out  one-cycle strobe after a credited goal
//   last_scorer  out  00 none, 01 player 1, 10 player 2
//   serve_hold   out  high during the post-goal faceoff hold
//   game_over    out  high once a player reaches WIN_SCORE
//   winner       out  00 none, 01 player 1, 10 player 2
module score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50000000,
  parameter int HOLD_W      = 26
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       goal1_in,
  input  logic       goal2_in,
  input  logic       new_game,
  output logic [2:0] score1,
  output logic [2:0] score2,
  output logic       goal_pulse,
  output logic [1:0] last_scorer,
  output logic       serve_hold,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t              r_state, w_state_n;
  logic [HOLD_W-1:0]   r_cnt, w_cnt_n;
  logic [2:0]          r_score1, r_score2, w_score1_n, w_score2_n;
  logic                r_goal_pulse, w_goal_pulse_n;
  logic [1:0]          r_last, w_last_n;
  logic                r_serve_hold, w_serve_hold_n;
  logic                r_game_over, w_game_over_n;
  logic [1:0]          r_winner, w_winner_n;
  logic                r_g1_q, r_g2_q;

  logic                w_ev1, w_ev2;
  logic [2:0]          w_s1_inc, w_s2_inc;

  // Rising-edge goal events; edge registers track the inputs in every state so
  // a level held across HOLD->PLAY or OVER->PLAY never re-scores.
  assign w_ev1    = goal1_in & ~r_g1_q;
  assign w_ev2    = goal2_in & ~r_g2_q;
  assign w_s1_inc = r_score1 + 3'd1;
  assign w_s2_inc = r_score2 + 3'd1;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= PLAY;
      r_cnt        <= '0;
      r_score1     <= 3'd0;
      r_score2     <= 3'd0;
      r_goal_pulse <= 1'b0;
      r_last       <= 2'b00;
      r_serve_hold <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= 2'b00;
      // Start high so an input already asserted during reset is not a goal.
      r_g1_q       <= 1'b1;
      r_g2_q       <= 1'b1;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_score1     <= w_score1_n;
      r_score2     <= w_score2_n;
      r_goal_pulse <= w_goal_pulse_n;
      r_last       <= w_last_n;
      r_serve_hold <= w_serve_hold_n;
      r_game_over  <= w_game_over_n;
      r_winner     <= w_winner_n;
      r_g1_q       <= goal1_in;
      r_g2_q       <= goal2_in;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_score1_n     = r_score1;
    w_score2_n     = r_score2;
    w_goal_pulse_n = 1'b0;
    w_last_n       = r_last;
    w_serve_hold_n = r_serve_hold;
    w_game_over_n  = r_game_over;
    w_winner_n     = r_winner;

    if (new_game) begin
      // Restart wins over any goal event in the same cycle.
      w_state_n      = PLAY;
      w_cnt_n        = '0;
      w_score1_n     = 3'd0;
      w_score2_n     = 3'd0;
      w_last_n       = 2'b00;
      w_serve_hold_n = 1'b0;
      w_game_over_n  = 1'b0;
      w_winner_n     = 2'b00;
    end else begin
      case (r_state)
        PLAY: begin
          // Player 1 wins a tie; player 2's simultaneous edge is simply lost.
          if (w_ev1) begin
            w_score1_n     = w_s1_inc;
            w_last_n       = 2'b01;
            w_goal_pulse_n = 1'b1;
            if (w_s1_inc == 3'(WIN_SCORE)) begin
              w_state_n     = OVER;
              w_game_over_n = 1'b1;
              w_winner_n    = 2'b01;
            end else begin
              w_state_n      = HOLD;
              w_serve_hold_n = 1'b1;
              w_cnt_n        = HOLD_W'(HOLD_CYCLES - 1);
            end
          end else if (w_ev2) begin
            w_score2_n     = w_s2_inc;
            w_last_n       = 2'b10;
            w_goal_pulse_n = 1'b1;
            if (w_s2_inc == 3'(WIN_SCORE)) begin
              w_state_n     = OVER;
              w_game_over_n = 1'b1;
              w_winner_n    = 2'b10;
            end else begin
              w_state_n      = HOLD;
              w_serve_hold_n = 1'b1;
              w_cnt_n        = HOLD_W'(HOLD_CYCLES - 1);
            end
          end
        end
        HOLD: begin
          // Loaded with HOLD_CYCLES-1, so serve_hold spans exactly HOLD_CYCLES.
          if (r_cnt == '0) begin
            w_state_n      = PLAY;
            w_serve_hold_n = 1'b0;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
        OVER: begin
          w_serve_hold_n = 1'b0;
        end
        default: begin
          w_state_n      = PLAY;
          w_serve_hold_n = 1'b0;
        end
      endcase
    end
  end

  assign score1      = r_score1;
  assign score2      = r_score2;
  assign goal_pulse  = r_goal_pulse;
  assign last_scorer = r_last;
  assign serve_hold  = r_serve_hold;
  assign game_over   = r_game_over;
  assign winner      = r_winner;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper
module tb_score_keeper;

  localparam int WIN  = 3;
  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       goal1_in = 1'b0;
  logic       goal2_in = 1'b0;
  logic       new_game = 1'b0;
  logic [2:0] score1, score2;
  logic       goal_pulse, serve_hold, game_over;
  logic [1:0] last_scorer, winner;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game-level view (scores, remaining hold cycles, over flag).
  int m_s1, m_s2, m_last, m_winner, m_hold_left;
  bit m_pulse, m_over, m_p1, m_p2;

  score_keeper #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD), .HOLD_W(3)) dut (
    .clock(clock), .rst(rst), .goal1_in(goal1_in), .goal2_in(goal2_in),
    .new_game(new_game), .score1(score1), .score2(score2),
    .goal_pulse(goal_pulse), .last_scorer(last_scorer), .serve_hold(serve_hold),
    .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  task automatic model_edge(input bit r, input bit g1, input bit g2, input bit ng);
    bit e1, e2;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_last = 0; m_winner = 0; m_hold_left = 0;
      m_pulse = 0; m_over = 0; m_p1 = 1; m_p2 = 1;
      return;
    end
    e1 = g1 && !m_p1;
    e2 = g2 && !m_p2;
    m_p1 = g1; m_p2 = g2;
    m_pulse = 0;
    if (ng) begin
      m_s1 = 0; m_s2 = 0; m_last = 0; m_winner = 0; m_hold_left = 0; m_over = 0;
    end else if (m_over) begin
      m_hold_left = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (e1 || e2) begin
      m_pulse = 1;
      if (e1) begin m_s1++; m_last = 1; end
      else begin m_s2++; m_last = 2; end
      if ((e1 ? m_s1 : m_s2) == WIN) begin
        m_over = 1; m_winner = m_last;
      end else begin
        m_hold_left = HOLD;
      end
    end
  endtask

  // One clock: drive on the falling edge, step model on the rising edge, settle.
  task automatic cyc(input bit r, input bit g1, input bit g2, input bit ng);
    @(negedge clock);
    rst = r; goal1_in = g1; goal2_in = g2; new_game = ng;
    @(posedge clock);
    model_edge(r, g1, g2, ng);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    n_checks++; if (score1 !== 3'd0) begin n_fail++; $display("FAIL reset_score1 got=%0d exp=0", score1); end
    n_checks++; if (score2 !== 3'd0) begin n_fail++; $display("FAIL reset_score2 got=%0d exp=0", score2); end
    n_checks++; if ({goal_pulse, serve_hold, game_over} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {goal_pulse, serve_hold, game_over}); end
    n_checks++; if ({last_scorer, winner} !== 4'b0000) begin n_fail++; $display("FAIL reset_ids got=%b exp=0000", {last_scorer, winner}); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0);
      n_checks++; if (score1 !== 3'd0 || goal_pulse !== 1'b0) begin n_fail++; $display("FAIL held_goal_after_reset cyc=%0d score1=%0d pulse=%b exp=0/0", i, score1, goal_pulse); end
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_goal_hold();
    int n_hold, n_pulse;
    n_hold = 0; n_pulse = 0;
    cyc(0, 0, 1, 0);
    n_checks++; if (score2 !== 3'd1 || last_scorer !== 2'b10) begin n_fail++; $display("FAIL goal2_credit score2=%0d last=%b exp=1/10", score2, last_scorer); end
    n_hold += serve_hold; n_pulse += goal_pulse;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, (i < 2), 0);
      n_hold += serve_hold; n_pulse += goal_pulse;
    end
    n_checks++; if (n_hold !== HOLD) begin n_fail++; $display("FAIL hold_length got=%0d exp=%0d", n_hold, HOLD); end
    n_checks++; if (n_pulse !== 1) begin n_fail++; $display("FAIL goal2_pulses got=%0d exp=1", n_pulse); end
    n_checks++; if (score2 !== 3'd1 || serve_hold !== 1'b0) begin n_fail++; $display("FAIL after_hold score2=%0d hold=%b exp=1/0", score2, serve_hold); end
  endtask

  task automatic test_hold_edge();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    n_checks++; if (score1 !== 3'd0 || serve_hold !== 1'b0) begin n_fail++; $display("FAIL edge_in_hold score1=%0d hold=%b exp=0/0", score1, serve_hold); end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    n_checks++; if (score1 !== 3'd1 || goal_pulse !== 1'b1) begin n_fail++; $display("FAIL second_edge score1=%0d pulse=%b exp=1/1", score1, goal_pulse); end
    for (int i = 0; i < HOLD + 1; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 0);
    n_checks++; if (score1 !== 3'd1 || score2 !== 3'd0 || last_scorer !== 2'b01) begin n_fail++; $display("FAIL simultaneous s1=%0d s2=%0d last=%b exp=1/0/01", score1, score2, last_scorer); end
    for (int i = 0; i < HOLD + 2; i++) cyc(0, 0, 0, 0);
    n_checks++; if (score2 !== 3'd0 || goal_pulse !== 1'b0) begin n_fail++; $display("FAIL discarded_p2 s2=%0d pulse=%b exp=0/0", score2, goal_pulse); end
  endtask

  task automatic test_win();
    cyc(0, 0, 0, 1);
    for (int g = 0; g < WIN; g++) begin
      cyc(0, 1, 0, 0);
      if (g == WIN - 1) begin
        n_checks++; if (game_over !== 1'b1 || winner !== 2'b01 || score1 !== 3'(WIN) || serve_hold !== 1'b0) begin n_fail++; $display("FAIL win over=%b win=%b s1=%0d hold=%b exp=1/01/%0d/0", game_over, winner, score1, serve_hold, WIN); end
      end
      for (int i = 0; i < HOLD + 1; i++) cyc(0, 0, 0, 0);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
    end
    n_checks++; if (score2 !== 3'd0 || game_over !== 1'b1 || score1 !== 3'(WIN) || goal_pulse !== 1'b0) begin n_fail++; $display("FAIL frozen s2=%0d over=%b s1=%0d pulse=%b exp=0/1/%0d/0", score2, game_over, score1, goal_pulse, WIN); end
  endtask

  task automatic test_new_game_rst();
    cyc(0, 0, 1, 1);
    n_checks++; if ({score1, score2} !== 6'd0 || {game_over, goal_pulse, serve_hold} !== 3'b000 || {winner, last_scorer} !== 4'b0000) begin n_fail++; $display("FAIL new_game s1=%0d s2=%0d flags=%b ids=%b exp=all zero", score1, score2, {game_over, goal_pulse, serve_hold}, {winner, last_scorer}); end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    n_checks++; if (score2 !== 3'd1 || serve_hold !== 1'b1) begin n_fail++; $display("FAIL play_after_new_game s2=%0d hold=%b exp=1/1", score2, serve_hold); end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_checks++; if ({score1, score2} !== 6'd0 || {game_over, goal_pulse, serve_hold} !== 3'b000 || {winner, last_scorer} !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_hold s1=%0d s2=%0d flags=%b ids=%b exp=all zero", score1, score2, {game_over, goal_pulse, serve_hold}, {winner, last_scorer}); end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit r, g1, g2, ng;
    g1 = 0; g2 = 0;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      ng = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) g1 = ~g1;
      if ($urandom_range(0, 3) == 0) g2 = ~g2;
      cyc(r, g1, g2, ng);
      n_checks++;
      if (score1 !== 3'(m_s1) || score2 !== 3'(m_s2) || goal_pulse !== m_pulse ||
          last_scorer !== 2'(m_last) || serve_hold !== (m_hold_left > 0) ||
          game_over !== m_over || winner !== 2'(m_winner)) begin
        n_fail++;
        $display("FAIL random cyc=%0d got s1=%0d s2=%0d p=%b l=%b h=%b o=%b w=%b exp s1=%0d s2=%0d p=%b l=%0d h=%b o=%b w=%0d",
                 i, score1, score2, goal_pulse, last_scorer, serve_hold, game_over, winner,
                 m_s1, m_s2, m_pulse, m_last, (m_hold_left > 0), m_over, m_winner);
      end
    end
  endtask

  initial begin
    test_reset();
    test_goal_hold();
    test_hold_edge();
    test_simultaneous();
    test_win();
    test_new_game_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Owns the two 3-bit player scores that feed the seven-segment scoreboard (score1 and score2).
- Converts goal-detect levels from the puck/collision logic into credited goals.
- After each credited goal, holds the faceoff (serve hold) for a fixed time.
- Detects the winning score and freezes the game until a new game is requested.

Parameters:
- WIN_SCORE, 7, score that ends the game; legal range 1..7.
- HOLD_CYCLES, 50000000, clock cycles that serve_hold stays asserted after a non-winning goal; must be >= 1.
- HOLD_W, 26, width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- goal1_in  input  1  level from puck logic: puck is in player 1's scoring goal (credits player 1); synchronous to clock.
- goal2_in  input  1  same as goal1_in, credits player 2.
- new_game  input  1  synchronous request to restart the game (already debounced and synchronised).
- score1  output  3  player 1 score, 0..WIN_SCORE.
- score2  output  3  player 2 score, 0..WIN_SCORE.
- goal_pulse  output  1  one-cycle strobe in the cycle after a goal is credited.
- last_scorer  output  2  00 none, 01 player 1, 10 player 2.
- serve_hold  output  1  high while play is frozen for the post-goal faceoff.
- game_over  output  1  high once a player reaches WIN_SCORE.
- winner  output  2  00 none, 01 player 1, 10 player 2; valid while game_over = 1.

Behaviour:
- Reset values:
  - score1 = score2 = 0.
  - goal_pulse = 0, last_scorer = 00, serve_hold = 0, game_over = 0, winner = 00.
  - State = PLAY, hold counter = 0.
  - Edge registers g1_q = g2_q = 1, so an input already high during reset never produces a goal.
- Edge detection:
  - g1_q and g2_q sample goal1_in and goal2_in on every clock, in every state.
  - A goal event for player n is goaln_in = 1 while gn_q = 0.
  - A goal input that stays high across a HOLD-to-PLAY transition therefore does not re-score.
- States: PLAY, HOLD, OVER. All outputs are registered.
- PLAY, goal event for player n:
  - At the same clock edge: scoren <= scoren + 1, last_scorer <= n, goal_pulse <= 1.
  - If scoren + 1 == WIN_SCORE: go to OVER, game_over <= 1, winner <= n.
  - Otherwise: go to HOLD, serve_hold <= 1, counter <= HOLD_CYCLES - 1.
- Simultaneous goal events in PLAY:
  - Player 1 is credited.
  - Player 2's event is discarded permanently; it does not score later.
- HOLD:
  - Goal events are ignored.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: go to PLAY and clear serve_hold.
  - serve_hold is high for exactly HOLD_CYCLES cycles.
- OVER:
  - Scores, winner and game_over are frozen.
  - Goal events are ignored.
  - serve_hold = 0.
  - Stays in OVER until new_game or rst.
- goal_pulse is high for exactly 1 cycle per credited goal and 0 otherwise.
- new_game:
  - Accepted in any state.
  - Has priority over a goal event in the same cycle; that event is discarded.
  - Next state: scores = 0, last_scorer = 00, winner = 00, game_over = 0, serve_hold = 0, goal_pulse = 0, state = PLAY.
  - Edge registers are not reset by new_game.
- rst:
  - Has priority over everything.
  - Mid-HOLD or in OVER it returns all outputs to their reset values on the next edge.
- Scores never exceed WIN_SCORE and never wrap; 3-bit arithmetic suffices given WIN_SCORE <= 7.
- Latency: a goal level first sampled high at edge N is reflected in score and goal_pulse after edge N.

Test Plan:
(All scenarios use WIN_SCORE=3, HOLD_CYCLES=4.)
1. Reset with goal1_in held high, then release rst, keeping goal1_in high -> score1 stays 0, goal_pulse never fires.
2. goal2_in pulse high for 3 cycles in PLAY -> score2 = 1, single goal_pulse, last_scorer = 10, serve_hold high exactly 4 cycles, then PLAY.
3. goal1_in rises during HOLD, stays high into PLAY, then falls and rises again -> only the second rising edge scores; score1 goes 0 to 1.
4. goal1_in and goal2_in rise in the same PLAY cycle -> score1 +1, score2 unchanged, last_scorer = 01.
5. Player 1 scores 3 goals (each separated by hold expiry) -> after the third, game_over = 1, winner = 01, score1 = 3, serve_hold = 0; further goal2 edges leave score2 unchanged.
6. new_game asserted in OVER together with a goal2 edge -> next cycle all scores 0, game_over = 0, state PLAY, no goal_pulse; rst asserted mid-HOLD -> all outputs at reset values next cycle.
